// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared widths and constants for the register file
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int REG_ZERO           = 0;

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - read/write port bundle for the register file
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] address_s1;
  logic [ADDR_WIDTH-1:0] address_s2;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0] data_dval;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] data_s1val;
  logic [DATA_WIDTH-1:0] data_s2val;

  modport master (
    output address_s1,
    output address_s2,
    output address_d,
    output data_dval,
    output write_enable,
    input  data_s1val,
    input  data_s2val
  );

  modport slave (
    input  address_s1,
    input  address_s2,
    input  address_d,
    input  data_dval,
    input  write_enable,
    output data_s1val,
    output data_s2val
  );

endinterface

// File: rtl/register_file_read_port.sv
// rtl/register_file_read_port.sv - one combinational read port with write bypass and $zero forcing
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] stored,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address_d,
  input  logic [DATA_WIDTH-1:0] data_dval,
  output logic [DATA_WIDTH-1:0] data
);

  logic read_zero;
  logic bypass_hit;

  assign read_zero  = (address == ADDR_WIDTH'(REG_ZERO));
  assign bypass_hit = write_enable && (address_d != ADDR_WIDTH'(REG_ZERO)) && (address_d == address);

  // Reset wins over bypass so a write held during reset never leaks out.
  always_comb begin
    data = '0;
    if (!reset_n || read_zero) begin
      data = '0;
    end else if (bypass_hit) begin
      data = data_dval;
    end else begin
      data = stored;
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 2**ADDR_WIDTH x DATA_WIDTH register file, two read ports, one write port
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic           clock,
  input  logic           reset_n,
  register_file_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  write_hit;

  assign write_hit = bus.write_enable && (bus.address_d != ADDR_WIDTH'(REG_ZERO));

  // Entry 0 is never written, so it holds its reset value of zero forever.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[bus.address_d] <= bus.data_dval;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_s1 (
    .reset_n      (reset_n),
    .address      (bus.address_s1),
    .stored       (regs[bus.address_s1]),
    .write_enable (bus.write_enable),
    .address_d    (bus.address_d),
    .data_dval    (bus.data_dval),
    .data         (bus.data_s1val)
  );

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_s2 (
    .reset_n      (reset_n),
    .address      (bus.address_s2),
    .stored       (regs[bus.address_s2]),
    .write_enable (bus.write_enable),
    .address_d    (bus.address_d),
    .data_dval    (bus.data_dval),
    .data         (bus.data_s2val)
  );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed and randomized checks of register_file against a behavioural model
module tb_register_file;

  logic clock;
  logic reset_n;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (rf_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] model [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Architectural view: reset forces zero, $zero reads zero, a live write to the same register is visible.
  function automatic logic [31:0] expect_read(input logic [4:0] addr);
    if (!reset_n) return 32'h0;
    if (addr == 5'd0) return 32'h0;
    if (rf_if.write_enable && rf_if.address_d != 5'd0 && rf_if.address_d == addr) return rf_if.data_dval;
    return model[addr];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    rf_if.write_enable = 1'b1;
    rf_if.address_d    = addr;
    rf_if.data_dval    = data;
    @(posedge clock);
    if (reset_n && addr != 5'd0) model[addr] = data;
    #1;
    rf_if.write_enable = 1'b0;
  endtask

  task automatic check_ports(input string tag);
    check_eq({tag, "_s1"}, rf_if.data_s1val, expect_read(rf_if.address_s1));
    check_eq({tag, "_s2"}, rf_if.data_s2val, expect_read(rf_if.address_s2));
  endtask

  logic [4:0]  reset_addrs [3];
  logic [4:0]  r_ad;
  logic [31:0] r_dv;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_model();
    reset_n            = 1'b0;
    rf_if.write_enable = 1'b0;
    rf_if.address_d    = '0;
    rf_if.data_dval    = '0;
    rf_if.address_s1   = '0;
    rf_if.address_s2   = '0;
    reset_addrs[0] = 5'd0;
    reset_addrs[1] = 5'd8;
    reset_addrs[2] = 5'd31;
    #12;

    for (int i = 0; i < 3; i++) begin
      rf_if.address_s1 = reset_addrs[i];
      rf_if.address_s2 = reset_addrs[i];
      #1;
      check_eq("reset_read_s1", rf_if.data_s1val, 32'h0);
      check_eq("reset_read_s2", rf_if.data_s2val, 32'h0);
    end

    @(negedge clock);
    reset_n = 1'b1;

    do_write(5'd8, 32'h0000_000F);
    rf_if.address_s1 = 5'd8;
    #1;
    check_eq("write8_read", rf_if.data_s1val, 32'h0000_000F);

    do_write(5'd0, 32'hDEAD_BEEF);
    rf_if.address_s1 = 5'd0;
    rf_if.address_s2 = 5'd0;
    #1;
    check_eq("zero_reg_s1", rf_if.data_s1val, 32'h0);
    check_eq("zero_reg_s2", rf_if.data_s2val, 32'h0);

    rf_if.address_s1 = 5'd8;
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    clear_model();
    #1;
    check_eq("async_reset_clears", rf_if.data_s1val, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_eq("after_reset_release", rf_if.data_s1val, 32'h0);

    // Write held across an edge while reset is asserted must neither bypass nor land.
    rf_if.address_s1 = 5'd9;
    @(negedge clock);
    rf_if.write_enable = 1'b1;
    rf_if.address_d    = 5'd9;
    rf_if.data_dval    = 32'hCAFE_F00D;
    reset_n            = 1'b0;
    #1;
    check_eq("reset_blocks_bypass", rf_if.data_s1val, 32'h0);
    @(posedge clock);
    #1;
    rf_if.write_enable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_eq("reset_blocks_write", rf_if.data_s1val, 32'h0);

    @(negedge clock);
    rf_if.write_enable = 1'b1;
    rf_if.address_d    = 5'd5;
    rf_if.data_dval    = 32'h1234_5678;
    rf_if.address_s2   = 5'd5;
    #1;
    check_eq("bypass_s2", rf_if.data_s2val, 32'h1234_5678);
    @(posedge clock);
    model[5] = 32'h1234_5678;
    #1;
    rf_if.write_enable = 1'b0;
    #1;
    check_eq("bypass_then_stored", rf_if.data_s2val, 32'h1234_5678);

    do_write(5'd3, 32'hA5A5_A5A5);
    do_write(5'd4, 32'h5A5A_5A5A);
    rf_if.address_s1 = 5'd3;
    rf_if.address_s2 = 5'd4;
    #1;
    check_eq("dual_read_s1", rf_if.data_s1val, 32'hA5A5_A5A5);
    check_eq("dual_read_s2", rf_if.data_s2val, 32'h5A5A_5A5A);

    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      r_ad = 5'($urandom_range(0, 31));
      r_dv = $urandom;
      rf_if.write_enable = 1'($urandom_range(0, 1));
      rf_if.address_d    = r_ad;
      rf_if.data_dval    = r_dv;
      rf_if.address_s1   = ($urandom_range(0, 3) == 0) ? r_ad : 5'($urandom_range(0, 31));
      rf_if.address_s2   = ($urandom_range(0, 7) == 0) ? rf_if.address_s1 : 5'($urandom_range(0, 31));
      #1;
      check_ports("rand_pre");
      if (rf_if.address_s1 == rf_if.address_s2)
        check_eq("rand_same_addr", rf_if.data_s1val, rf_if.data_s2val);
      @(posedge clock);
      if (rf_if.write_enable && r_ad != 5'd0) model[r_ad] = r_dv;
      #1;
      check_ports("rand_post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, which sets the register and data-port width.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 5, which sets the address width; the file holds 2**ADDR_WIDTH registers (32 by default).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all writes occur on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port address_s1, input, ADDR_WIDTH bits, the source-1 read address.
REQ-007 The block SHALL have port address_s2, input, ADDR_WIDTH bits, the source-2 read address.
REQ-008 The block SHALL have port address_d, input, ADDR_WIDTH bits, the destination write address.
REQ-009 The block SHALL have port data_dval, input, DATA_WIDTH bits, the write data.
REQ-010 The block SHALL have port write_enable, input, 1 bit, the write strobe (active high).
REQ-011 The block SHALL have port data_s1val, output, DATA_WIDTH bits, the source-1 read data.
REQ-012 The block SHALL have port data_s2val, output, DATA_WIDTH bits, the source-2 read data.

Function
REQ-013 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits each.
REQ-014 When write_enable=1 at a rising clock edge and address_d!=0, register[address_d] SHALL take data_dval at that edge.
REQ-015 When write_enable=0, no register SHALL change.
REQ-016 Register 0 SHALL read as 0 at all times; writes to address 0 SHALL be ignored (MIPS $zero).
REQ-017 Reads SHALL be combinational (zero-cycle latency): data_s1val = register[address_s1] and data_s2val = register[address_s2], with no clock involved.
REQ-018 Write-through bypass: while write_enable=1, address_d!=0 and address_d equals a read address, that read port SHALL output data_dval combinationally.
REQ-019 Both read ports SHALL operate independently; identical read addresses SHALL return identical data.
REQ-020 X/Z on unused inputs SHALL NOT corrupt stored state when write_enable=0.
REQ-021 No handshake SHALL exist; a write completes in one cycle.
REQ-022 The block SHALL have no state machine.

Reset
REQ-023 When reset_n=0, all registers SHALL clear to 0 immediately, independent of clock, and data_s1val and data_s2val SHALL read 0 combinationally.
REQ-024 While reset_n=0, writes SHALL be blocked, including the bypass path.
REQ-025 When reset_n rises, the next rising clock edge SHALL be able to write normally.
REQ-026 A reset asserted during a write cycle SHALL leave the target register at 0.

Structure
REQ-027 A shared package SHALL hold the DATA_WIDTH and ADDR_WIDTH defaults, plus constant REG_ZERO=0.
REQ-028 One sub-module, register_file_read_port (address compare, bypass, zero-force mux), SHALL be instantiated twice, once for s1 and once for s2.
REQ-029 The storage array and write logic SHALL reside in the top level.

Verification
REQ-030 The bench SHALL drive reset_n=0, then read addresses 0, 8 and 31 on both ports; both ports SHALL return 0x00000000.
REQ-031 The bench SHALL write 0x0000000F to address 8 (write_enable=1 for one edge), then set write_enable=0 and address_s1=8; data_s1val SHALL be 0x0000000F.
REQ-032 The bench SHALL write 0xDEADBEEF to address 0; data_s1val and data_s2val at address 0 SHALL read 0x00000000.
REQ-033 The bench SHALL hold write_enable=1, address_d=5, data_dval=0x12345678 with address_s2=5 before the clock edge; data_s2val SHALL be 0x12345678 immediately (bypass).
REQ-034 The bench SHALL write 0xA5A5A5A5 to address 3 and 0x5A5A5A5A to address 4, then set address_s1=3 and address_s2=4; the ports SHALL return the two values respectively.
REQ-035 The bench SHALL assert reset_n=0 mid-cycle after the REQ-031 write; data_s1val at address 8 SHALL become 0 without waiting for a clock edge.
